// File: rtl/reu_dma_seq_pkg.sv
// reu_pkg: shared types for the REU DMA sequencer.
//   xfer_e  : transfer type encoding as presented on XferType
//   state_e : sequencer state encoding
//   next_op : the state that follows a given state within one byte's sequence
package reu_pkg;

    typedef enum logic [1:0] {
        XFER_STASH  = 2'b00,   // C64 -> REU
        XFER_FETCH  = 2'b01,   // REU -> C64
        XFER_SWAP   = 2'b10,
        XFER_VERIFY = 2'b11
    } xfer_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_C_RD  = 3'd2,
        ST_C_WR  = 3'd3,
        ST_R_RD  = 3'd4,
        ST_R_WR  = 3'd5,
        ST_STEP  = 3'd6
    } state_e;

    // ST_START yields the first access of a byte; ST_STEP is reached after the last.
    function automatic state_e next_op(input state_e cur, input xfer_e xt);
        state_e nx;
        nx = ST_IDLE;
        case (cur)
            ST_START: nx = (xt == XFER_FETCH) ? ST_R_RD : ST_C_RD;
            ST_C_RD:  nx = (xt == XFER_STASH) ? ST_R_WR : ST_R_RD;
            ST_R_RD: begin
                case (xt)
                    XFER_FETCH: nx = ST_C_WR;
                    XFER_SWAP:  nx = ST_R_WR;
                    default:    nx = ST_STEP;
                endcase
            end
            ST_R_WR:  nx = (xt == XFER_SWAP) ? ST_C_WR : ST_STEP;
            ST_C_WR:  nx = ST_STEP;
            default:  nx = ST_IDLE;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/reu_dma_seq_if.sv
// reu_dma_seq_if: C64 bus and SDRAM port bundle of the REU DMA sequencer.
//   master : sequencer side (drives strobes, requests and write data)
//   slave  : C64 bus / SDRAM controller side
//   BA, CRD, CWD, CRE, CWE, DMA     : C64 bus available, read/write data, strobes, DMA request
//   RamReq, RamWE, RamAck, RamRD/WD : SDRAM request handshake and data
interface reu_dma_seq_if;
    logic       BA;
    logic [7:0] CRD;
    logic [7:0] CWD;
    logic       CRE;
    logic       CWE;
    logic       DMA;
    logic       RamReq;
    logic       RamWE;
    logic       RamAck;
    logic [7:0] RamRD;
    logic [7:0] RamWD;

    modport master (
        input  BA, CRD, RamAck, RamRD,
        output CWD, CRE, CWE, DMA, RamReq, RamWE, RamWD
    );

    modport slave (
        output BA, CRD, RamAck, RamRD,
        input  CWD, CRE, CWE, DMA, RamReq, RamWE, RamWD
    );
endinterface

// File: rtl/reu_dma_seq.sv
// reu_dma_seq: REU DMA byte sequencer. All state updates on the falling edge of PHI2.
// Ports:
//   PHI2, nReset          : clock (falling-edge active) and async active-low reset
//   Execute, XferType     : start request and transfer type from the register block
//   Length1               : remaining length equals one
//   bus (master)          : C64 bus and SDRAM handshake
//   IncCA/IncREUA/DecLen  : per-byte step pulses to the register block
//   XferEnd/SetEndBlock/SetFault : completion and status pulses
//   RegReset              : register-block reset, stretched one cycle past nReset
//   Busy                  : high outside IDLE
// Build option: define REU_VERIFY_STOP_EN to end a verify transfer at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for Execute
// START  | DMA asserted, waiting for BA
// C_RD   | C64 read: wait BA, one-cycle CRE, capture CRD into C
// C_WR   | C64 write: wait BA, one-cycle CWE with CWD = R
// R_RD   | SDRAM read held until RamAck, capture RamRD into R
// R_WR   | SDRAM write of C held until RamAck
// STEP   | address/length step; end or restart the byte sequence
module reu_dma_seq
    import reu_pkg::*;
(
    input  logic          PHI2,
    input  logic          nReset,
    input  logic          Execute,
    input  logic [1:0]    XferType,
    input  logic          Length1,
    reu_dma_seq_if.master bus,
    output logic          IncCA,
    output logic          IncREUA,
    output logic          DecLen,
    output logic          XferEnd,
    output logic          SetEndBlock,
    output logic          SetFault,
    output logic          RegReset,
    output logic          Busy
);

    state_e     state_q, state_d, nxt;
    xfer_e      type_q, type_d;
    logic [7:0] c_q, c_d, r_q, r_d;
    logic       cre_q, cre_d, cwe_q, cwe_d;
    logic       inc_q, inc_d, fault_q, fault_d;
    logic       end_q, end_d, endblk_q, endblk_d;
    logic       reg_rst_q, reg_rst_d;
    logic       stop;

    always_ff @(negedge PHI2 or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            type_q    <= XFER_STASH;
            c_q       <= 8'h00;
            r_q       <= 8'h00;
            cre_q     <= 1'b0;
            cwe_q     <= 1'b0;
            inc_q     <= 1'b0;
            fault_q   <= 1'b0;
            end_q     <= 1'b0;
            endblk_q  <= 1'b0;
            reg_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            c_q       <= c_d;
            r_q       <= r_d;
            cre_q     <= cre_d;
            cwe_q     <= cwe_d;
            inc_q     <= inc_d;
            fault_q   <= fault_d;
            end_q     <= end_d;
            endblk_q  <= endblk_d;
            reg_rst_q <= reg_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        c_d       = c_q;
        r_d       = r_q;
        cre_d     = 1'b0;
        cwe_d     = 1'b0;
        fault_d   = 1'b0;
        end_d     = 1'b0;
        endblk_d  = 1'b0;
        reg_rst_d = 1'b0;
        stop      = 1'b0;
        nxt       = next_op(state_q, type_q);

        case (state_q)
            ST_IDLE: begin
                if (Execute) begin
                    state_d = ST_START;
                    type_d  = xfer_e'(XferType);
                end
            end
            ST_START: begin
                if (bus.BA) state_d = nxt;
            end
            // The strobe is a registered cycle of its own; data is taken at its end.
            ST_C_RD: begin
                if (cre_q) begin
                    c_d     = bus.CRD;
                    state_d = nxt;
                end else if (bus.BA) begin
                    cre_d = 1'b1;
                end
            end
            ST_C_WR: begin
                if (cwe_q) state_d = nxt;
                else if (bus.BA) cwe_d = 1'b1;
            end
            ST_R_RD: begin
                if (bus.RamAck) begin
                    r_d     = bus.RamRD;
                    state_d = nxt;
                    fault_d = (type_q == XFER_VERIFY) && (bus.RamRD != c_q);
                end
            end
            ST_R_WR: begin
                if (bus.RamAck) state_d = nxt;
            end
            ST_STEP: begin
                stop = Length1;
`ifdef REU_VERIFY_STOP_EN
                if (fault_q) stop = 1'b1;
`endif
                if (stop) begin
                    state_d  = ST_IDLE;
                    end_d    = 1'b1;
                    endblk_d = Length1;
                end else begin
                    state_d = next_op(ST_START, type_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Step pulses are registered on entry so they coincide with the STEP cycle.
        inc_d = (state_d == ST_STEP) && (state_q != ST_STEP);
    end

    assign Busy        = (state_q != ST_IDLE);
    assign bus.DMA     = Busy;
    assign bus.CRE     = cre_q;
    assign bus.CWE     = cwe_q;
    assign bus.CWD     = r_q;
    assign bus.RamReq  = (state_q == ST_R_RD) || (state_q == ST_R_WR);
    assign bus.RamWE   = (state_q == ST_R_WR);
    assign bus.RamWD   = c_q;
    assign IncCA       = inc_q;
    assign IncREUA     = inc_q;
    assign DecLen      = inc_q;
    assign SetFault    = fault_q;
    assign XferEnd     = end_q;
    assign SetEndBlock = endblk_q;
    assign RegReset    = reg_rst_q;

endmodule

// File: tb/tb_reu_dma_seq.sv
module tb_reu_dma_seq;
    import reu_pkg::*;

    localparam int EV_CRD  = 0;
    localparam int EV_CWR  = 1;
    localparam int EV_RWR  = 2;
    localparam int EV_RRD  = 3;
    localparam int EV_STEP = 4;
    localparam int EV_END  = 5;
`ifdef REU_VERIFY_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       PHI2 = 1'b0;
    logic       nReset = 1'b0;
    logic       Execute = 1'b0;
    logic [1:0] XferType = 2'b00;
    logic       Length1;
    logic       IncCA, IncREUA, DecLen, XferEnd, SetEndBlock, SetFault, RegReset, Busy;

    int         len = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         ram_delay = 0;
    bit         ba_rand = 1'b0;
    bit         spur_en = 1'b0;
    bit         stray_en = 1'b0;
    bit         end_seen = 1'b0;
    ev_t        exp_q[$];
    logic [7:0] crd_q[$];
    logic [7:0] ram_q[$];
    logic [7:0] cv[8];
    logic [7:0] rv[8];

    assign Length1 = (len == 1);

    reu_dma_seq_if bus ();

    reu_dma_seq dut (
        .PHI2        (PHI2),
        .nReset      (nReset),
        .Execute     (Execute),
        .XferType    (XferType),
        .Length1     (Length1),
        .bus         (bus.master),
        .IncCA       (IncCA),
        .IncREUA     (IncREUA),
        .DecLen      (DecLen),
        .XferEnd     (XferEnd),
        .SetEndBlock (SetEndBlock),
        .SetFault    (SetFault),
        .RegReset    (RegReset),
        .Busy        (Busy)
    );

    initial forever #5 PHI2 = ~PHI2;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string ev_name(input int k);
        case (k)
            EV_CRD:  return "c_read";
            EV_CWR:  return "c_write";
            EV_RWR:  return "ram_write";
            EV_RRD:  return "ram_read";
            EV_STEP: return "step";
            default: return "end";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected event: got %s data %0h, expected none at %0t", ev_name(k), d, $time);
        end else begin
            e = exp_q.pop_front();
            check({"event kind (expected ", ev_name(e.kind), ")"}, 32'(k), 32'(e.kind));
            check({"event data ", ev_name(e.kind)}, 32'(d), 32'(e.data));
        end
    endtask

    // Scoreboard monitor: samples on the rising edge, away from the active falling edge.
    initial begin : monitor
        logic       pr_req, pr_we;
        logic [7:0] pr_wd;
        pr_req = 1'b0;
        pr_we  = 1'b0;
        pr_wd  = 8'h00;
        forever begin
            @(posedge PHI2);
            if (nReset) begin
                if (bus.RamAck && pr_req) observe(pr_we ? EV_RWR : EV_RRD, pr_we ? pr_wd : 8'h00);
                if (bus.CRE) observe(EV_CRD, 8'h00);
                if (bus.CWE) observe(EV_CWR, bus.CWD);
                if (IncCA) observe(EV_STEP, {5'b0, SetFault, IncREUA, DecLen});
                if (XferEnd) begin
                    observe(EV_END, {7'b0, SetEndBlock});
                    end_seen = 1'b1;
                end
                if (SetEndBlock && !XferEnd) check("endblock without xferend", 32'(XferEnd), 32'd1);
                if (SetFault && !IncCA) check("fault outside step", 32'(IncCA), 32'd1);
                if (bus.DMA !== Busy) check("dma equals busy", 32'(bus.DMA), 32'(Busy));
            end
            pr_req = bus.RamReq;
            pr_we  = bus.RamWE;
            pr_wd  = bus.RamWD;
        end
    end

    // SDRAM responder: acks after a delay, occasionally acks with no request pending.
    initial begin : ram_resp
        int d;
        forever begin
            @(posedge PHI2);
            if (bus.RamReq && nReset) begin
                d = (ram_delay != 0) ? ram_delay : int'($urandom_range(1, 3));
                repeat (d - 1) @(posedge PHI2);
                #1;
                bus.RamAck = 1'b1;
                if (!bus.RamWE) bus.RamRD = (ram_q.size() != 0) ? ram_q.pop_front() : 8'h00;
                @(posedge PHI2);
                #1 bus.RamAck = 1'b0;
            end else if (spur_en && $urandom_range(0, 9) == 0) begin
                #1 bus.RamAck = 1'b1;
                bus.RamRD = 8'($urandom);
                @(posedge PHI2);
                #1 bus.RamAck = 1'b0;
            end
        end
    end

    // C64 side: advance read data after the strobe cycle has been consumed.
    initial begin : c64_resp
        forever begin
            @(posedge PHI2);
            if (bus.CRE) begin
                @(negedge PHI2);
                #1;
                if (crd_q.size() != 0) void'(crd_q.pop_front());
                bus.CRD = (crd_q.size() != 0) ? crd_q[0] : 8'h00;
            end
        end
    end

    // Register-block length model: DecLen takes effect at the falling edge ending STEP.
    initial begin : len_model
        forever begin
            @(posedge PHI2);
            if (DecLen) begin
                @(negedge PHI2);
                #1 len = len - 1;
            end
        end
    end

    initial begin : ba_drive
        forever begin
            @(posedge PHI2);
            #1;
            if (ba_rand) bus.BA = ($urandom_range(0, 3) != 0);
        end
    end

    // Execute pulses while busy must be ignored.
    initial begin : stray_exec
        forever begin
            @(posedge PHI2);
            if (stray_en && Busy && !IncCA && $urandom_range(0, 7) == 0) begin
                #1 Execute = 1'b1;
                @(posedge PHI2);
                #1 Execute = 1'b0;
            end
        end
    end

    // Reference model: expected event list for a whole transfer from the byte values.
    task automatic start_xfer(input logic [1:0] t, input int l);
        logic f;
        for (int i = 0; i < l; i++) begin
            case (t)
                2'b00: begin
                    push_ev(EV_CRD, 8'h00); push_ev(EV_RWR, cv[i]);
                    crd_q.push_back(cv[i]);
                end
                2'b01: begin
                    push_ev(EV_RRD, 8'h00); push_ev(EV_CWR, rv[i]);
                    ram_q.push_back(rv[i]);
                end
                2'b10: begin
                    push_ev(EV_CRD, 8'h00); push_ev(EV_RRD, 8'h00);
                    push_ev(EV_RWR, cv[i]); push_ev(EV_CWR, rv[i]);
                    crd_q.push_back(cv[i]); ram_q.push_back(rv[i]);
                end
                default: begin
                    push_ev(EV_CRD, 8'h00); push_ev(EV_RRD, 8'h00);
                    crd_q.push_back(cv[i]); ram_q.push_back(rv[i]);
                end
            endcase
            f = (t == 2'b11) && (cv[i] != rv[i]);
            push_ev(EV_STEP, {5'b0, f, 2'b11});
            if (STOP_EN && f) begin
                push_ev(EV_END, {7'b0, (i == l - 1)});
                break;
            end
            if (i == l - 1) push_ev(EV_END, 8'h01);
        end
        len      = l;
        XferType = t;
        bus.CRD  = (crd_q.size() != 0) ? crd_q[0] : 8'h00;
        end_seen = 1'b0;
        @(posedge PHI2);
        #1 Execute = 1'b1;
        @(posedge PHI2);
        #1 Execute = 1'b0;
    endtask

    task automatic finish_xfer(input string name);
        for (int i = 0; i < 3000 && !end_seen; i++) @(posedge PHI2);
        check({name, " end seen"}, 32'(end_seen), 32'd1);
        repeat (2) @(posedge PHI2);
        check({name, " events left"}, 32'(exp_q.size()), 32'd0);
        check({name, " busy after end"}, 32'(Busy), 32'd0);
        if (!end_seen) begin
            #1 nReset = 1'b0;
            repeat (2) @(posedge PHI2);
            @(negedge PHI2);
            #1 nReset = 1'b1;
            repeat (2) @(posedge PHI2);
        end
        exp_q.delete();
        crd_q.delete();
        ram_q.delete();
    endtask

    function automatic logic [27:0] out_vec();
        return {IncCA, IncREUA, DecLen, XferEnd, SetEndBlock, SetFault, Busy,
                bus.DMA, bus.CRE, bus.CWE, bus.RamReq, bus.RamWE, bus.RamWD, bus.CWD};
    endfunction

    initial begin : main
        bus.BA     = 1'b1;
        bus.CRD    = 8'h00;
        bus.RamAck = 1'b0;
        bus.RamRD  = 8'h00;

        // Reset state and RegReset stretch
        repeat (3) @(posedge PHI2);
        #1;
        check("outputs during reset", 32'(out_vec()), 32'd0);
        check("regreset during reset", 32'(RegReset), 32'd1);
        @(negedge PHI2);
        #1 nReset = 1'b1;
        @(posedge PHI2);
        check("regreset first cycle", 32'(RegReset), 32'd1);
        @(posedge PHI2);
        check("regreset second cycle", 32'(RegReset), 32'd0);

        // Stash, length 3, ack two cycles after request
        ram_delay = 2;
        cv[0] = 8'hA1; cv[1] = 8'hB2; cv[2] = 8'hC3;
        start_xfer(2'b00, 3);
        finish_xfer("stash3");

        // Fetch, length 1
        ram_delay = 0;
        rv[0] = 8'h5A;
        start_xfer(2'b01, 1);
        finish_xfer("fetch1");

        // Swap, length 1
        cv[0] = 8'h11; rv[0] = 8'h22;
        start_xfer(2'b10, 1);
        finish_xfer("swap1");

        // Verify, length 4, mismatch on second byte
        cv[0] = 8'h01; cv[1] = 8'h02; cv[2] = 8'h03; cv[3] = 8'h04;
        rv[0] = 8'h01; rv[1] = 8'hFF; rv[2] = 8'h03; rv[3] = 8'h04;
        start_xfer(2'b11, 4);
        finish_xfer("verify4");

        // BA low for five cycles while in C_RD
        cv[0] = 8'h3C;
        start_xfer(2'b00, 1);
        for (int i = 0; i < 20 && !bus.DMA; i++) @(posedge PHI2);
        check("dma raised", 32'(bus.DMA), 32'd1);
        @(posedge PHI2);
        #1 bus.BA = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge PHI2);
            check("cre held off while ba low", 32'(bus.CRE), 32'd0);
        end
        #1 bus.BA = 1'b1;
        @(posedge PHI2);
        check("cre after ba rises", 32'(bus.CRE), 32'd1);
        finish_xfer("ba_stall");

        // Reset in the middle of an SDRAM write
        ram_delay = 6;
        cv[0] = 8'h77; cv[1] = 8'h88;
        start_xfer(2'b00, 2);
        for (int i = 0; i < 50 && !(bus.RamReq && bus.RamWE); i++) @(posedge PHI2);
        check("ram write pending", 32'({bus.RamReq, bus.RamWE}), 32'd3);
        #1 nReset = 1'b0;
        #1;
        check("outputs low at reset", 32'(out_vec()), 32'd0);
        check("regreset at reset", 32'(RegReset), 32'd1);
        exp_q.delete();
        crd_q.delete();
        ram_q.delete();
        repeat (3) @(posedge PHI2);
        @(negedge PHI2);
        #1 nReset = 1'b1;
        @(posedge PHI2);
        check("regreset after release", 32'(RegReset), 32'd1);
        check("idle after release", 32'(Busy), 32'd0);
        @(posedge PHI2);
        check("regreset cleared", 32'(RegReset), 32'd0);
        repeat (10) @(posedge PHI2);
        ram_delay = 0;
        cv[0] = 8'h5E; rv[0] = 8'hE5;
        start_xfer(2'b10, 1);
        finish_xfer("after_reset");

        // Randomized transfers with BA stalls, stray Execute and spurious RamAck
        ba_rand  = 1'b1;
        spur_en  = 1'b1;
        stray_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic [1:0] t;
            int         l;
            t = 2'($urandom_range(0, 3));
            l = int'($urandom_range(1, 5));
            for (int i = 0; i < 8; i++) begin
                cv[i] = 8'($urandom);
                rv[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cv[i];
            end
            start_xfer(t, l);
            finish_xfer("random");
        end
        ba_rand  = 1'b0;
        spur_en  = 1'b0;
        stray_en = 1'b0;
        #1 bus.BA = 1'b1;
        repeat (4) @(posedge PHI2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reu_dma_seq.md
REU_DMA_SEQ -- requirements
Module: reu_dma_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no parameters.
REQ-002 PHI2  in  1  C64 PHI2 clock; all state updates on falling edge.
REQ-003 nReset  in  1  asynchronous active-low reset.
REQ-004 Execute  in  1  start request from register block.
REQ-005 XferType  in  2  00 stash (C64->REU), 01 fetch (REU->C64), 10 swap, 11 verify.
REQ-006 Length1  in  1  transfer length register equals 1.
REQ-007 BA  in  1  C64 bus available; low stalls C64-side accesses.
REQ-008 CRD / CWD  in / out  8 / 8  C64 read data / write data.
REQ-009 CRE, CWE  out  1  C64 bus read / write strobe, one cycle each.
REQ-010 DMA  out  1  C64 DMA request, high while busy.
REQ-011 RamReq, RamWE  out  1  SDRAM request, write qualifier; held until RamAck.
REQ-012 RamAck  in  1  SDRAM access complete, one-cycle pulse; RamRD valid with it.
REQ-013 RamRD / RamWD  in / out  8 / 8  SDRAM read data / write data.
REQ-014 IncCA, IncREUA, DecLen  out  1  registered step pulses to register block.
REQ-015 XferEnd, SetEndBlock, SetFault  out  1  registered one-cycle completion/status pulses.
REQ-016 RegReset  out  1  register-block reset, high while nReset low and for the first cycle after nReset deasserts.
REQ-017 Busy  out  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, START, C_RD, C_WR, R_RD, R_WR, STEP.
REQ-019 IDLE + Execute SHALL go to START next cycle; Execute outside IDLE SHALL be ignored.
REQ-020 START SHALL assert DMA and wait for BA high, then enter the first state of the selected sequence.
REQ-021 Sequences per byte: stash C_RD->R_WR; fetch R_RD->C_WR; swap C_RD->R_RD->R_WR->C_WR; verify C_RD->R_RD.
REQ-022 C_RD and C_WR SHALL wait while BA low, then assert the strobe for exactly one cycle; C_RD latches CRD into data register C.
REQ-023 R_RD and R_WR SHALL hold RamReq (RamWE=1 for R_WR, RamWD = register C) until RamAck; R_RD latches RamRD into data register R on RamAck.
REQ-024 In swap, C_WR SHALL drive CWD from register R; in fetch, C_WR drives CWD from register R.
REQ-025 In verify, R_RD completion with R != C SHALL pulse SetFault in the STEP cycle.
REQ-026 STEP SHALL pulse IncCA, IncREUA and DecLen together for one cycle.
REQ-027 In STEP, if Length1 was high, the block SHALL pulse XferEnd and SetEndBlock and return to IDLE; otherwise it restarts the sequence.
REQ-028 Length1 SHALL be sampled in STEP only, before the DecLen pulse takes effect.
REQ-029 RamAck outside R_RD/R_WR SHALL be ignored.

Reset
REQ-030 nReset low SHALL force IDLE, clear the data registers, and drive every output low except RegReset, from any state including mid-transfer.

Configuration
REQ-031 With REU_VERIFY_STOP_EN defined, a verify mismatch SHALL end the transfer in that STEP: XferEnd and SetFault pulse, plus SetEndBlock only if Length1.
REQ-032 Without REU_VERIFY_STOP_EN, a verify mismatch SHALL pulse SetFault and the transfer SHALL continue to Length1.

Structure
REQ-033 Package reu_pkg SHALL hold the XferType constants and the state encoding.
REQ-034 The block SHALL be a single module; no sub-module is natural.

Verification
REQ-035 Stash, Length 3, BA high, RamAck 2 cycles after RamReq: 3 CRE, 3 RamWE writes, 3 STEP pulses, then XferEnd + SetEndBlock, Busy low.
REQ-036 Fetch, Length 1, RamRD=0x5A: CWE once with CWD=0x5A, then XferEnd.
REQ-037 Swap, Length 1, CRD=0x11, RamRD=0x22: RamWD=0x11 and CWD=0x22.
REQ-038 Verify, Length 4, mismatch on byte 2: with REU_VERIFY_STOP_EN, SetFault + XferEnd after 2 STEPs and no SetEndBlock; without it, SetFault, 4 STEPs, then XferEnd + SetEndBlock.
REQ-039 BA low for 5 cycles during C_RD: CRE held off and fires one cycle after BA rises.
REQ-040 nReset asserted during R_WR with RamReq high: outputs low at once, IDLE after release, RegReset high one cycle after release, and the next Execute is accepted.
